// File: rtl/mips_pipe_ctrl.sv
// Pipelined main control for the 5-stage MIPS core: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use stall generation and branch/jump flushing.
// Optional feature macro: MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN (registered undefined-opcode flag).
module mips_pipe_ctrl #(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned LOAD_USE_STALLS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        branch_taken,
    output logic        stall,
    output logic        flush_if_id,
    output logic        id_jump,
    output logic        ex_reg_dst,
    output logic        ex_alu_src,
    output logic        ex_branch,
    output logic [1:0]  ex_alu_op,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        mem_branch,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic        illegal_op
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJ     = 6'b000010;

    // The hazard cycle itself is the first stall cycle, so the counter covers the rest.
    localparam logic [1:0] StallInit = 2'(LOAD_USE_STALLS - 1);

    logic [5:0]            id_op;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  unused_instr;

    assign id_op        = id_instr[31:26];
    assign id_rs        = id_instr[21 +: REG_ADDR_W];
    assign id_rt        = id_instr[16 +: REG_ADDR_W];
    assign unused_instr = ^id_instr[15:0];

    // Decoded control word for the ID-stage instruction
    logic       dec_reg_dst, dec_alu_src, dec_mem_to_reg, dec_reg_write;
    logic       dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_reads_rt;
    logic [1:0] dec_alu_op;

    // Register state
    logic                  idex_reg_dst_q, idex_alu_src_q, idex_mem_to_reg_q, idex_reg_write_q;
    logic                  idex_mem_read_q, idex_mem_write_q, idex_branch_q;
    logic [1:0]            idex_alu_op_q;
    logic [REG_ADDR_W-1:0] idex_rt_q;
    logic                  idex_reg_dst_d, idex_alu_src_d, idex_mem_to_reg_d, idex_reg_write_d;
    logic                  idex_mem_read_d, idex_mem_write_d, idex_branch_d;
    logic [1:0]            idex_alu_op_d;
    logic [REG_ADDR_W-1:0] idex_rt_d;
    logic                  exmem_mem_read_q, exmem_mem_write_q, exmem_branch_q;
    logic                  exmem_reg_write_q, exmem_mem_to_reg_q;
    logic                  exmem_mem_read_d, exmem_mem_write_d, exmem_branch_d;
    logic                  exmem_reg_write_d, exmem_mem_to_reg_d;
    logic                  memwb_reg_write_q, memwb_mem_to_reg_q;
    logic                  memwb_reg_write_d, memwb_mem_to_reg_d;
    logic [1:0]            stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic bubble;

    // Opcode decode; every unlisted opcode yields an all-zero word
    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_alu_op     = 2'b00;
        dec_reads_rt   = 1'b0;
        case (id_op)
            OpLw: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
            end
            OpSw: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_reads_rt  = 1'b1;
            end
            OpRType: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
                dec_reads_rt  = 1'b1;
            end
            OpAddi: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpBeq: begin
                dec_branch   = 1'b1;
                dec_alu_op   = 2'b01;
                dec_reads_rt = 1'b1;
            end
            OpSlti: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b11;
            end
            OpJ: begin
                dec_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection, stall/flush outputs and pipeline next-state
    always_comb begin
        hazard = (stall_cnt_q == 2'd0) && id_valid && idex_mem_read_q &&
                 (idex_rt_q != '0) &&
                 ((idex_rt_q == id_rs) || (dec_reads_rt && (idex_rt_q == id_rt)));

        // A taken branch overrides any stall in progress
        stall       = !branch_taken && (hazard || (stall_cnt_q != 2'd0));
        id_jump     = id_valid && dec_jump && !stall && !branch_taken;
        flush_if_id = id_jump || branch_taken;
        bubble      = !id_valid || dec_jump || stall || branch_taken;

        idex_reg_dst_d    = bubble ? 1'b0 : dec_reg_dst;
        idex_alu_src_d    = bubble ? 1'b0 : dec_alu_src;
        idex_mem_to_reg_d = bubble ? 1'b0 : dec_mem_to_reg;
        idex_reg_write_d  = bubble ? 1'b0 : dec_reg_write;
        idex_mem_read_d   = bubble ? 1'b0 : dec_mem_read;
        idex_mem_write_d  = bubble ? 1'b0 : dec_mem_write;
        idex_branch_d     = bubble ? 1'b0 : dec_branch;
        idex_alu_op_d     = bubble ? 2'b00 : dec_alu_op;
        idex_rt_d         = bubble ? '0 : id_rt;

        exmem_mem_read_d   = branch_taken ? 1'b0 : idex_mem_read_q;
        exmem_mem_write_d  = branch_taken ? 1'b0 : idex_mem_write_q;
        exmem_branch_d     = branch_taken ? 1'b0 : idex_branch_q;
        exmem_reg_write_d  = branch_taken ? 1'b0 : idex_reg_write_q;
        exmem_mem_to_reg_d = branch_taken ? 1'b0 : idex_mem_to_reg_q;

        memwb_reg_write_d  = exmem_reg_write_q;
        memwb_mem_to_reg_d = exmem_mem_to_reg_q;

        if (branch_taken) begin
            stall_cnt_d = 2'd0;
        end else if (hazard) begin
            stall_cnt_d = StallInit;
        end else if (stall_cnt_q != 2'd0) begin
            stall_cnt_d = stall_cnt_q - 2'd1;
        end else begin
            stall_cnt_d = 2'd0;
        end
    end

    // Pipeline control registers and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_reg_dst_q     <= 1'b0;
            idex_alu_src_q     <= 1'b0;
            idex_mem_to_reg_q  <= 1'b0;
            idex_reg_write_q   <= 1'b0;
            idex_mem_read_q    <= 1'b0;
            idex_mem_write_q   <= 1'b0;
            idex_branch_q      <= 1'b0;
            idex_alu_op_q      <= 2'b00;
            idex_rt_q          <= '0;
            exmem_mem_read_q   <= 1'b0;
            exmem_mem_write_q  <= 1'b0;
            exmem_branch_q     <= 1'b0;
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= 1'b0;
            memwb_reg_write_q  <= 1'b0;
            memwb_mem_to_reg_q <= 1'b0;
            stall_cnt_q        <= 2'd0;
        end else begin
            idex_reg_dst_q     <= idex_reg_dst_d;
            idex_alu_src_q     <= idex_alu_src_d;
            idex_mem_to_reg_q  <= idex_mem_to_reg_d;
            idex_reg_write_q   <= idex_reg_write_d;
            idex_mem_read_q    <= idex_mem_read_d;
            idex_mem_write_q   <= idex_mem_write_d;
            idex_branch_q      <= idex_branch_d;
            idex_alu_op_q      <= idex_alu_op_d;
            idex_rt_q          <= idex_rt_d;
            exmem_mem_read_q   <= exmem_mem_read_d;
            exmem_mem_write_q  <= exmem_mem_write_d;
            exmem_branch_q     <= exmem_branch_d;
            exmem_reg_write_q  <= exmem_reg_write_d;
            exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
            memwb_reg_write_q  <= memwb_reg_write_d;
            memwb_mem_to_reg_q <= memwb_mem_to_reg_d;
            stall_cnt_q        <= stall_cnt_d;
        end
    end

    assign ex_reg_dst    = idex_reg_dst_q;
    assign ex_alu_src    = idex_alu_src_q;
    assign ex_branch     = idex_branch_q;
    assign ex_alu_op     = idex_alu_op_q;
    assign mem_mem_read  = exmem_mem_read_q;
    assign mem_mem_write = exmem_mem_write_q;
    assign mem_branch    = exmem_branch_q;
    assign wb_reg_write  = memwb_reg_write_q;
    assign wb_mem_to_reg = memwb_mem_to_reg_q;

`ifdef MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic op_known;

    // Every defined opcode asserts at least one of these, so none set means undefined
    always_comb begin
        op_known  = dec_reg_write || dec_mem_write || dec_branch || dec_jump;
        illegal_d = id_valid && !op_known && !stall && !branch_taken;
    end

    // One-cycle trap flag aligned with the ex_* stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed self-checking bench for mips_pipe_ctrl; instance u_dut1 uses one load-use bubble,
// u_dut2 uses two. Both share the same stimulus.
module tb_mips_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        branch_taken;

    logic       stall1, flush1, jump1, reg_dst1, alu_src1, branch1;
    logic [1:0] alu_op1;
    logic       mread1, mwrite1, mbranch1, wb_rw1, wb_m2r1, ill1;
    logic       stall2, flush2, jump2, reg_dst2, alu_src2, branch2;
    logic [1:0] alu_op2;
    logic       mread2, mwrite2, mbranch2, wb_rw2, wb_m2r2, ill2;

    int n_vec = 0;
    int n_err = 0;

    mips_pipe_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .branch_taken(branch_taken), .stall(stall1), .flush_if_id(flush1), .id_jump(jump1),
        .ex_reg_dst(reg_dst1), .ex_alu_src(alu_src1), .ex_branch(branch1), .ex_alu_op(alu_op1),
        .mem_mem_read(mread1), .mem_mem_write(mwrite1), .mem_branch(mbranch1),
        .wb_reg_write(wb_rw1), .wb_mem_to_reg(wb_m2r1), .illegal_op(ill1)
    );

    mips_pipe_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .branch_taken(branch_taken), .stall(stall2), .flush_if_id(flush2), .id_jump(jump2),
        .ex_reg_dst(reg_dst2), .ex_alu_src(alu_src2), .ex_branch(branch2), .ex_alu_op(alu_op2),
        .mem_mem_read(mread2), .mem_mem_write(mwrite2), .mem_branch(mbranch2),
        .wb_reg_write(wb_rw2), .wb_mem_to_reg(wb_m2r2), .illegal_op(ill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
        return {op, rs, rt, 16'h1820};
    endfunction

    task automatic set(input logic [31:0] i, input logic v, input logic bt);
        id_instr     = i;
        id_valid     = v;
        branch_taken = bt;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] exw1();
        return {reg_dst1, alu_src1, branch1, alu_op1};
    endfunction

    function automatic logic [4:0] exw2();
        return {reg_dst2, alu_src2, branch2, alu_op2};
    endfunction

    localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
    localparam logic [5:0] OpAddi = 6'b001000, OpBeq = 6'b000100, OpSlti = 6'b001010;
    localparam logic [5:0] OpJ = 6'b000010, OpBad = 6'b111111;

    logic exp_ill;

    initial begin
`ifdef MIPS_PIPE_CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst_n = 1'b0;
        set(32'h0, 1'b0, 1'b0);
        #7;
        check_eq("rst_exw", {27'h0, exw1()}, 32'h0);
        check_eq("rst_mem", {29'h0, mread1, mwrite1, mbranch1}, 32'h0);
        check_eq("rst_wb", {30'h0, wb_rw1, wb_m2r1}, 32'h0);
        check_eq("rst_comb", {29'h0, stall1, flush1, jump1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // lw $2,0($1) through the pipe
        set(ins(OpLw, 5'd1, 5'd2), 1'b1, 1'b0);
        #2 check_eq("lw_nostall", {31'h0, stall1}, 32'h0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("lw_ex", {27'h0, exw1()}, 32'h08);
        nxt();
        #2 check_eq("lw_mem", {30'h0, mread1, mwrite1}, 32'h2);
        nxt();
        #2 check_eq("lw_wb", {30'h0, wb_rw1, wb_m2r1}, 32'h3);
        nxt();

        // lw $2 then add $3,$2,$4
        set(ins(OpLw, 5'd1, 5'd2), 1'b1, 1'b0);
        nxt();
        set(ins(OpR, 5'd2, 5'd4), 1'b1, 1'b0);
        #2 check_eq("lu_stall1_c0", {31'h0, stall1}, 32'h1);
        check_eq("lu_stall2_c0", {31'h0, stall2}, 32'h1);
        check_eq("lu_noflush", {31'h0, flush1}, 32'h0);
        nxt();
        #2 check_eq("lu_stall1_c1", {31'h0, stall1}, 32'h0);
        check_eq("lu_stall2_c1", {31'h0, stall2}, 32'h1);
        check_eq("lu_bubble1", {27'h0, exw1()}, 32'h0);
        check_eq("lu_bubble2", {27'h0, exw2()}, 32'h0);
        nxt();
        #2 check_eq("lu_add1", {29'h0, reg_dst1, alu_op1}, 32'h6);
        check_eq("lu_stall2_c2", {31'h0, stall2}, 32'h0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("lu_add2", {29'h0, reg_dst2, alu_op2}, 32'h6);
        nxt();

        // lw $0 then use of $0: no hazard
        set(ins(OpLw, 5'd1, 5'd0), 1'b1, 1'b0);
        nxt();
        set(ins(OpR, 5'd0, 5'd0), 1'b1, 1'b0);
        #2 check_eq("rt0_stall1", {31'h0, stall1}, 32'h0);
        check_eq("rt0_stall2", {31'h0, stall2}, 32'h0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        nxt();

        // sw reads rt; then async reset mid-stall on u_dut2
        set(ins(OpLw, 5'd1, 5'd7), 1'b1, 1'b0);
        nxt();
        set(ins(OpSw, 5'd1, 5'd7), 1'b1, 1'b0);
        #2 check_eq("sw_rt_stall", {31'h0, stall1}, 32'h1);
        nxt();
        #2 check_eq("rst_mid_pre", {31'h0, stall2}, 32'h1);
        rst_n = 1'b0;
        #1 check_eq("rst_mid_stall", {31'h0, stall2}, 32'h0);
        rst_n = 1'b1;
        set(32'h0, 1'b0, 1'b0);
        nxt();
        #2 check_eq("rst_mid_after", {31'h0, stall2}, 32'h0);
        nxt();

        // addi does not read rt, but does read rs
        set(ins(OpLw, 5'd1, 5'd7), 1'b1, 1'b0);
        nxt();
        set(ins(OpAddi, 5'd1, 5'd7), 1'b1, 1'b0);
        #2 check_eq("addi_rt_nostall", {31'h0, stall1}, 32'h0);
        set(ins(OpAddi, 5'd7, 5'd1), 1'b1, 1'b0);
        #1 check_eq("addi_rs_stall", {31'h0, stall1}, 32'h1);
        set(ins(OpR, 5'd7, 5'd7), 1'b0, 1'b0);
        #1 check_eq("invalid_nostall", {31'h0, stall1}, 32'h0);
        set(32'h0, 1'b0, 1'b0);
        nxt();
        nxt();

        // branch_taken coincident with a hazard
        set(ins(OpLw, 5'd1, 5'd2), 1'b1, 1'b0);
        nxt();
        set(ins(OpR, 5'd2, 5'd4), 1'b1, 1'b1);
        #2 check_eq("bt_haz_stall", {30'h0, stall1, stall2}, 32'h0);
        check_eq("bt_haz_flush", {30'h0, flush1, flush2}, 32'h3);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("bt_exmem_zero", {30'h0, mread1, mread2}, 32'h0);
        check_eq("bt_idex_zero", {27'h0, exw1()}, 32'h0);
        check_eq("bt_cnt_clear", {31'h0, stall2}, 32'h0);
        nxt();
        #2 check_eq("bt_wb_zero", {31'h0, wb_rw1}, 32'h0);
        nxt();

        // branch_taken during the second stall cycle of u_dut2
        set(ins(OpLw, 5'd1, 5'd2), 1'b1, 1'b0);
        nxt();
        set(ins(OpR, 5'd2, 5'd4), 1'b1, 1'b0);
        nxt();
        set(ins(OpR, 5'd2, 5'd4), 1'b1, 1'b1);
        #2 check_eq("bt_stall_stall", {31'h0, stall2}, 32'h0);
        check_eq("bt_stall_flush", {31'h0, flush2}, 32'h1);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("bt_stall_idex", {27'h0, exw2()}, 32'h0);
        check_eq("bt_stall_exmem", {29'h0, mread2, mwrite2, mbranch2}, 32'h0);
        nxt();
        nxt();

        // j then addi
        set(ins(OpJ, 5'd0, 5'd0), 1'b1, 1'b0);
        #2 check_eq("j_jump_flush", {29'h0, jump1, flush1, stall1}, 32'h6);
        nxt();
        set(ins(OpAddi, 5'd1, 5'd3), 1'b1, 1'b0);
        #2 check_eq("j_bubble", {27'h0, exw1()}, 32'h0);
        check_eq("j_over", {30'h0, jump1, flush1}, 32'h0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("addi_ex", {27'h0, exw1()}, 32'h08);
        nxt();

        // beq then slti
        set(ins(OpBeq, 5'd1, 5'd2), 1'b1, 1'b0);
        nxt();
        set(ins(OpSlti, 5'd1, 5'd9), 1'b1, 1'b0);
        #2 check_eq("beq_ex", {27'h0, exw1()}, 32'h05);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("beq_mem", {31'h0, mbranch1}, 32'h1);
        check_eq("slti_ex", {27'h0, exw1()}, 32'h0b);
        nxt();
        #2 check_eq("slti_mem", {30'h0, mbranch1, wb_rw1}, 32'h0);
        nxt();
        #2 check_eq("slti_wb", {30'h0, wb_rw1, wb_m2r1}, 32'h2);

        // lw with id_valid=0 is a bubble
        set(ins(OpLw, 5'd1, 5'd2), 1'b0, 1'b0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("invalid_bubble", {27'h0, exw1()}, 32'h0);

        // undefined opcode
        set(ins(OpBad, 5'd1, 5'd2), 1'b1, 1'b0);
        #2 check_eq("ill_pre", {31'h0, ill1}, 32'h0);
        nxt();
        set(32'h0, 1'b0, 1'b0);
        #2 check_eq("ill_flag", {31'h0, ill1}, {31'h0, exp_ill});
        check_eq("ill_bubble", {27'h0, exw1()}, 32'h0);
        nxt();
        #2 check_eq("ill_one_cycle", {31'h0, ill1}, 32'h0);
        check_eq("ill_mem", {29'h0, mread1, mwrite1, mbranch1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
